// File: rtl/difficulty_round_ctrl.sv
// ============================================================================
// Module   : difficulty_round_ctrl
// Brief    : Latches the difficulty level at game start, then runs NUM_Q timed
//            questions. Provides the question ROM address, a per-question
//            countdown and the running score.
// Revision : 1.0
// ============================================================================
`default_nettype none

module difficulty_round_ctrl #(
    parameter int TICK_DIV   = 50000000,
    parameter int EASY_LIMIT = 15,
    parameter int MED_LIMIT  = 10,
    parameter int HARD_LIMIT = 5,
    parameter int NUM_Q      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       LoggedIn_easy,
    input  logic       LoggedIn_medium,
    input  logic       LoggedIn_hard,
    input  logic       start,
    input  logic       answer_valid,
    input  logic       answer_correct,
    output logic [4:0] rom_addr,
    output logic [2:0] question_idx,
    output logic [3:0] timer_sec,
    output logic [3:0] score,
    output logic [1:0] level,
    output logic       busy,
    output logic       timeout,
    output logic       level_err,
    output logic       game_over
);

    localparam int             DIV_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [2:0]     c_LAST_Q   = 3'(NUM_Q - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ASK  = 2'd1,
        S_NEXT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;

    logic [2:0] w_sel;
    logic       w_onehot;
    logic       w_none;
    logic [1:0] w_new_level;
    logic       w_tick;
    logic       w_last_q;
    logic [2:0] w_idx_inc;

    function automatic logic [3:0] f_limit(input logic [1:0] lv);
        case (lv)
            2'b01:   f_limit = 4'(EASY_LIMIT);
            2'b10:   f_limit = 4'(MED_LIMIT);
            2'b11:   f_limit = 4'(HARD_LIMIT);
            default: f_limit = 4'd0;
        endcase
    endfunction

    function automatic logic [4:0] f_base(input logic [1:0] lv);
        case (lv)
            2'b10:   f_base = 5'd8;
            2'b11:   f_base = 5'd16;
            default: f_base = 5'd0;
        endcase
    endfunction

    assign w_sel     = {LoggedIn_easy, LoggedIn_medium, LoggedIn_hard};
    assign w_onehot  = (w_sel == 3'b100) || (w_sel == 3'b010) || (w_sel == 3'b001);
    assign w_none    = (w_sel == 3'b000);
    assign w_tick    = (r_div == c_DIV_LAST);
    assign w_last_q  = (question_idx == c_LAST_Q);
    assign w_idx_inc = question_idx + 3'd1;

    always_comb begin
        w_new_level = 2'b00;
        case (w_sel)
            3'b100:  w_new_level = 2'b01;
            3'b010:  w_new_level = 2'b10;
            3'b001:  w_new_level = 2'b11;
            default: w_new_level = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_div        <= '0;
            rom_addr     <= 5'd0;
            question_idx <= 3'd0;
            timer_sec    <= 4'd0;
            score        <= 4'd0;
            level        <= 2'b00;
            busy         <= 1'b0;
            timeout      <= 1'b0;
            level_err    <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            timeout   <= 1'b0;
            level_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_onehot) begin
                            level        <= w_new_level;
                            question_idx <= 3'd0;
                            score        <= 4'd0;
                            timer_sec    <= f_limit(w_new_level);
                            r_div        <= '0;
                            rom_addr     <= f_base(w_new_level);
                            busy         <= 1'b1;
                            r_state      <= S_ASK;
                        end else begin
                            level_err <= 1'b1;
                        end
                    end
                end

                S_ASK: begin
                    // Logout outranks both a pending answer and a tick.
                    if (w_none) begin
                        r_state      <= S_IDLE;
                        busy         <= 1'b0;
                        score        <= 4'd0;
                        level        <= 2'b00;
                        timer_sec    <= 4'd0;
                        question_idx <= 3'd0;
                        rom_addr     <= 5'd0;
                        r_div        <= '0;
                    end else if (answer_valid) begin
                        score   <= score + {3'b000, answer_correct};
                        r_state <= S_NEXT;
                    end else if (w_tick) begin
                        r_div <= '0;
                        if (timer_sec == 4'd1) begin
                            timer_sec <= 4'd0;
                            timeout   <= 1'b1;
                            r_state   <= S_NEXT;
                        end else begin
                            timer_sec <= timer_sec - 4'd1;
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end

                S_NEXT: begin
                    if (w_none) begin
                        r_state      <= S_IDLE;
                        busy         <= 1'b0;
                        score        <= 4'd0;
                        level        <= 2'b00;
                        timer_sec    <= 4'd0;
                        question_idx <= 3'd0;
                        rom_addr     <= 5'd0;
                        r_div        <= '0;
                    end else if (w_last_q) begin
                        busy      <= 1'b0;
                        game_over <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        question_idx <= w_idx_inc;
                        timer_sec    <= f_limit(level);
                        r_div        <= '0;
                        rom_addr     <= f_base(level) + {2'b00, w_idx_inc};
                        r_state      <= S_ASK;
                    end
                end

                S_DONE: begin
                    // Result stays on display until the player logs out.
                    if (w_none) begin
                        game_over    <= 1'b0;
                        level        <= 2'b00;
                        score        <= 4'd0;
                        question_idx <= 3'd0;
                        timer_sec    <= 4'd0;
                        rom_addr     <= 5'd0;
                        r_state      <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
